// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Request-side controller in front of the 256x64 RAM banks on the shared
// memory bus. One load/store request at a time is accepted over a valid/ready
// handshake, the bank bus is driven, and a response is returned over a second
// valid/ready handshake. Byte-masked stores are done by read-modify-write;
// addresses that map to no populated bank are answered with resp_err.
//
// Ports:
//   clock, reset_n         - system clock, synchronous active-low reset
//   req_valid/req_ready    - request handshake (req_ready = idle)
//   req_write, req_addr,
//   req_wdata, req_be      - request payload ([63:56] bank, [55:8] zero, [7:0] word)
//   resp_valid/resp_ready  - response handshake
//   resp_rdata, resp_err   - load data (0 for stores/errors), decode error flag
//   mem_address, mem_in,
//   mem_write              - registered bank bus (banks sample on negedge)
//   mem_out                - shared bank read-data bus, captured one posedge later
//   busy                   - controller is not idle
module ram_access_ctrl #(
  parameter int NUM_BANKS = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_address,
  output logic [63:0] mem_in,
  output logic        mem_write,
  input  logic [63:0] mem_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } state_t;

  // Nine bits so a fully populated 256-bank configuration still compares correctly.
  localparam logic [8:0] NUM_BANKS_W = 9'(NUM_BANKS);

  state_t      state_r;
  state_t      next_state_s;

  // Request attributes latched at acceptance for use in later states.
  logic        op_write_r;
  logic        op_partial_r;
  logic [63:0] wdata_r;
  logic [7:0]  be_r;

  logic        accept_s;
  logic        decode_err_s;
  logic        be_none_s;
  logic        be_full_s;

  logic        op_write_s;
  logic        op_partial_s;
  logic [63:0] wdata_s;
  logic [7:0]  be_s;
  logic        resp_valid_s;
  logic [63:0] resp_rdata_s;
  logic        resp_err_s;
  logic [63:0] mem_address_s;
  logic [63:0] mem_in_s;
  logic        mem_write_s;

  // Byte-lane merge for read-modify-write: enabled lanes take the new data.
  function automatic logic [63:0] merge_bytes(input logic [63:0] new_data,
                                              input logic [63:0] old_data,
                                              input logic [7:0]  be);
    logic [63:0] merged;
    merged = old_data;
    for (int i = 0; i < 8; i++) begin
      merged[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
    return merged;
  endfunction

  assign req_ready    = (state_r == IDLE);
  assign busy         = (state_r != IDLE);
  assign accept_s     = req_valid & req_ready;
  assign decode_err_s = ({1'b0, req_addr[63:56]} >= NUM_BANKS_W) || (req_addr[55:8] != 48'd0);
  assign be_none_s    = (req_be == 8'h00);
  assign be_full_s    = (req_be == 8'hFF);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (decode_err_s || (req_write && be_none_s)) begin
            next_state_s = RESP;
          end else begin
            next_state_s = ACCESS;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (op_partial_r) begin
          next_state_s = MERGE_WR;
        end else begin
          next_state_s = RESP;
        end
      end
      MERGE_WR: begin
        next_state_s = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output/datapath next values; mem_write defaults low so it can only be
  // high for the single cycle following a write-issuing state.
  always_comb begin
    op_write_s    = op_write_r;
    op_partial_s  = op_partial_r;
    wdata_s       = wdata_r;
    be_s          = be_r;
    resp_rdata_s  = resp_rdata;
    resp_err_s    = resp_err;
    mem_address_s = mem_address;
    mem_in_s      = mem_in;
    mem_write_s   = 1'b0;
    // Response is presented from the first cycle in RESP until the handshake.
    resp_valid_s  = (next_state_s == RESP);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          op_write_s   = req_write;
          op_partial_s = req_write && !be_none_s && !be_full_s;
          wdata_s      = req_wdata;
          be_s         = req_be;
          resp_rdata_s = 64'd0;
          resp_err_s   = decode_err_s;
          if (!decode_err_s && !(req_write && be_none_s)) begin
            mem_address_s = req_addr;
            if (req_write && be_full_s) begin
              mem_in_s    = req_wdata;
              mem_write_s = 1'b1;
            end else begin
              mem_write_s = 1'b0;
            end
          end else begin
            mem_address_s = mem_address;
          end
        end else begin
          resp_err_s = resp_err;
        end
      end
      ACCESS: begin
        if (!op_write_r) begin
          resp_rdata_s = mem_out;
        end else if (op_partial_r) begin
          mem_in_s    = merge_bytes(wdata_r, mem_out, be_r);
          mem_write_s = 1'b1;
        end else begin
          mem_write_s = 1'b0;
        end
      end
      MERGE_WR: begin
        mem_write_s = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          resp_err_s = 1'b0;
        end else begin
          resp_err_s = resp_err;
        end
      end
      default: begin
        mem_write_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and latched request attributes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_write_r   <= 1'b0;
      op_partial_r <= 1'b0;
      wdata_r      <= 64'd0;
      be_r         <= 8'd0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 64'd0;
      resp_err     <= 1'b0;
      mem_address  <= 64'd0;
      mem_in       <= 64'd0;
      mem_write    <= 1'b0;
    end else begin
      op_write_r   <= op_write_s;
      op_partial_r <= op_partial_s;
      wdata_r      <= wdata_s;
      be_r         <= be_s;
      resp_valid   <= resp_valid_s;
      resp_rdata   <= resp_rdata_s;
      resp_err     <= resp_err_s;
      mem_address  <= mem_address_s;
      mem_in       <= mem_in_s;
      mem_write    <= mem_write_s;
    end
  end

endmodule
